// File: rtl/alu_flag_arbiter.sv
// alu_flag_arbiter
// Shares one combinational ALU/flag generator between two requesters. Each
// accepted op walks IDLE -> EXEC -> RESP -> IDLE. The ALU result and flags are
// captured in EXEC and held on the response channel until it is accepted.
// The architectural flag register flags_q is updated selectively by op code.
//
// Configuration macro: ALU_ARB_FIXED_PRIORITY_EN
//   defined   : req0 always wins simultaneous requests
//   undefined : round-robin arbitration; last-grant pointer resets to req1
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqX_valid/ready         requester handshake (ready is the grant cycle)
//   reqX_op, reqX_a, reqX_b  op code and N-bit operands
//   alu_select, alu_a, alu_b drive to the shared ALU (0 while idle)
//   alu_result, alu_flags    combinational ALU return (bit0 zero, bit1 negative)
//   rsp_*                    response channel (valid/ready, id, result, flags)
//   flags_q                  architectural flag register
module alu_flag_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic [3:0]   alu_select,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_result,
    input  logic [1:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic [1:0]   rsp_flags,
    output logic [1:0]   flags_q
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic                gnt_id_q,     gnt_id_d;
    logic [OP_W-1:0]     alu_select_q, alu_select_d;
    logic [N-1:0]        alu_a_q,      alu_a_d;
    logic [N-1:0]        alu_b_q,      alu_b_d;
    logic                rsp_valid_q,  rsp_valid_d;
    logic                rsp_id_q,     rsp_id_d;
    logic [N-1:0]        rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0]   rsp_flags_q,  rsp_flags_d;
    logic [FLAG_W-1:0]   flags_d;

    logic pick1_c;
    logic grant_c;

    // Arbitration: choose which valid requester would be granted this cycle
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    assign pick1_c = req1_valid && !req0_valid;
`else
    logic last_q, last_d;
    // last_q == 0 means req0 was granted last, so req1 now has priority
    assign pick1_c = req1_valid && (!req0_valid || !last_q);
`endif

    // Grants happen only in IDLE and never while reset is asserted
    assign grant_c    = !rst && (state_q == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = grant_c && !pick1_c;
    assign req1_ready = grant_c &&  pick1_c;

    assign alu_select = alu_select_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        alu_select_d = alu_select_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        flags_d      = flags_q;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
        last_d       = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (grant_c) begin
                    state_d      = S_EXEC;
                    gnt_id_d     = pick1_c;
                    alu_select_d = pick1_c ? req1_op : req0_op;
                    alu_a_d      = pick1_c ? req1_a  : req0_a;
                    alu_b_d      = pick1_c ? req1_b  : req0_b;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
                    last_d       = pick1_c;
`endif
                end
            end
            S_EXEC: begin
                state_d      = S_RESP;
                rsp_valid_d  = 1'b1;
                rsp_id_d     = gnt_id_q;
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                // Zero flag is only architecturally visible for op 4
                if (alu_select_q == OP_W'(4)) begin
                    flags_d[0] = alu_flags[0];
                end
                // Negative flag for ops 0..5, 9 and 10
                if ((alu_select_q <= OP_W'(5)) || (alu_select_q == OP_W'(9)) ||
                    (alu_select_q == OP_W'(10))) begin
                    flags_d[1] = alu_flags[1];
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d      = S_IDLE;
                    rsp_valid_d  = 1'b0;
                    alu_select_d = '0;
                    alu_a_d      = '0;
                    alu_b_d      = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_id_q     <= 1'b0;
            alu_select_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            flags_q      <= '0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            gnt_id_q     <= gnt_id_d;
            alu_select_q <= alu_select_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            flags_q      <= flags_d;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            last_q       <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_flag_arbiter.sv
// Testbench for alu_flag_arbiter: transaction-level reference model with
// randomized requests, plus directed sequences for flag updates, response
// backpressure and reset during execution.
module tb_alu_flag_arbiter;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   alu_select;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic [1:0]   alu_flags;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_result;
    logic [1:0]   rsp_flags;
    logic [1:0]   flags_q;

    always #5 clk = ~clk;

    alu_flag_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .flags_q(flags_q)
    );

    // Behavioural ALU used both as the DUT's shared ALU and by the model
    function automatic logic [N-1:0] alu_fn(input logic [3:0] op,
                                           input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a << 1;
            4'd7:    return {a[0], a[N-1:1]};
            default: return a + b + N'(op);
        endcase
    endfunction

    function automatic logic [1:0] flag_fn(input logic [N-1:0] r);
        return {r[N-1], (r == '0)};
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_select, alu_a, alu_b);
        alu_flags  = flag_fn(alu_result);
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: pending requests per requester, arbitration
    // history and the architectural flags
    bit           pend[2];
    logic [3:0]   p_op[2];
    logic [N-1:0] p_a[2], p_b[2];
    bit           m_last;
    logic [1:0]   m_flags;
    bit           auto_fill;
    int           grants0;

    task automatic refill();
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(3) != 0) begin
                pend[i] = 1'b1;
                p_op[i] = 4'($urandom_range(15));
                p_a[i]  = N'($urandom);
                p_b[i]  = N'($urandom);
            end
        end
    endtask

    task automatic drive_reqs();
        req0_valid = pend[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
        req1_valid = pend[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [N-1:0] a,
                           input logic [N-1:0] b);
        pend[i] = 1'b1; p_op[i] = op; p_a[i] = a; p_b[i] = b;
    endtask

    // One transaction window; entered and left on a falling edge
    task automatic run_one(input int hold, input bit rst_exec);
        bit           g;
        logic [3:0]   t_op;
        logic [N-1:0] t_a, t_b, e_res;
        logic [1:0]   e_fl;
        if (auto_fill) refill();
        drive_reqs();
        #1;
        check_eq("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("idle_alu_select", 32'(alu_select), 32'd0);
        if (!pend[0] && !pend[1]) begin
            check_eq("noreq_ready", 32'({req0_ready, req1_ready}), 32'd0);
            @(posedge clk); @(negedge clk);
            return;
        end
        if (pend[0] && pend[1]) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            g = 1'b0;
`else
            g = ~m_last;
`endif
        end else begin
            g = pend[1];
        end
        check_eq("grant_ready0", 32'(req0_ready), 32'(g == 1'b0));
        check_eq("grant_ready1", 32'(req1_ready), 32'(g == 1'b1));
        t_op = p_op[g]; t_a = p_a[g]; t_b = p_b[g];
        e_res = alu_fn(t_op, t_a, t_b);
        e_fl  = flag_fn(e_res);
        pend[g] = 1'b0;
        m_last  = g;
        if (g == 1'b0) grants0++;
        @(posedge clk); @(negedge clk);

        // EXEC cycle
        if (auto_fill) refill();
        drive_reqs();
        #1;
        check_eq("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check_eq("exec_alu_select", 32'(alu_select), 32'(t_op));
        check_eq("exec_alu_a", 32'(alu_a), 32'(t_a));
        check_eq("exec_alu_b", 32'(alu_b), 32'(t_b));
        check_eq("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        if (rst_exec) begin
            rst = 1'b1;
            @(posedge clk); @(negedge clk);
            drive_reqs();
            #1;
            check_eq("rstexec_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("rstexec_flags", 32'(flags_q), 32'd0);
            check_eq("rstexec_ready", 32'({req0_ready, req1_ready}), 32'd0);
            check_eq("rstexec_alu_select", 32'(alu_select), 32'd0);
            m_flags = 2'b00;
            m_last  = 1'b1;
            rst = 1'b0;
            return;
        end
        if (t_op == 4'd4) m_flags[0] = e_fl[0];
        if (t_op <= 4'd5 || t_op == 4'd9 || t_op == 4'd10) m_flags[1] = e_fl[1];
        @(posedge clk); @(negedge clk);

        // RESP cycles, with hold cycles of backpressure before acceptance
        for (int k = 0; k <= hold; k++) begin
            rsp_ready = (k == hold);
            if (auto_fill) refill();
            drive_reqs();
            #1;
            check_eq("resp_valid", 32'(rsp_valid), 32'd1);
            check_eq("resp_id", 32'(rsp_id), 32'(g));
            check_eq("resp_result", 32'(rsp_result), 32'(e_res));
            check_eq("resp_flags", 32'(rsp_flags), 32'(e_fl));
            check_eq("resp_flags_q", 32'(flags_q), 32'(m_flags));
            check_eq("resp_ready_low", 32'({req0_ready, req1_ready}), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        auto_fill = 1'b0;
        m_last = 1'b1;
        m_flags = 2'b00;
        grants0 = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b1; p_op[i] = 4'd0; p_a[i] = '0; p_b[i] = '0;
        end
        drive_reqs();
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_rsp_fields", 32'({rsp_id, rsp_result, rsp_flags}), 32'd0);
        check_eq("reset_flags", 32'(flags_q), 32'd0);
        check_eq("reset_alu", 32'({alu_select, alu_a, alu_b}), 32'd0);
        rst = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;

        // Both valid after reset: req0 first, then req1
        set_req(0, 4'd4, N'(3), N'(3));
        set_req(1, 4'd0, N'(1), N'(2));
        run_one(0, 1'b0);
        check_eq("first_zero_flag", 32'(flags_q[0]), 32'd1);
        run_one(0, 1'b0);

        // Build flags 2'b11, then an op that must leave them untouched
        set_req(0, 4'd4, N'(5), N'(5));
        run_one(0, 1'b0);
        set_req(0, 4'd5, N'(0), N'(0));
        run_one(0, 1'b0);
        check_eq("flags_set_11", 32'(flags_q), 32'd3);
        set_req(1, 4'd7, N'(1), N'(0));
        run_one(0, 1'b0);
        check_eq("op7_flags_hold", 32'(flags_q), 32'd3);

        // Five cycles of response backpressure
        set_req(0, 4'd1, N'(2), N'(9));
        run_one(5, 1'b0);

        // Reset during EXEC discards the op
        set_req(1, 4'd3, N'(8), N'(1));
        run_one(0, 1'b1);

        // Both continuously valid for four ops
        grants0 = 0;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) set_req(i, 4'($urandom_range(15)), N'($urandom), N'($urandom));
            end
            run_one(0, 1'b0);
        end
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        check_eq("fixed_grants0", 32'(grants0), 32'd4);
`else
        check_eq("rr_grants0", 32'(grants0), 32'd2);
`endif

        // Randomized traffic
        auto_fill = 1'b1;
        for (int n = 0; n < 200; n++) begin
            run_one(int'($urandom_range(3)), ($urandom_range(19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_flag_arbiter.md
ALU_FLAG_ARBITER -- requirements
Module: alu_flag_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, ALU operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester has an op pending.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  op accepted this cycle.
REQ-006 SHALL have ports req0_op/req1_op  input  4  ALU select code; req0_a, req0_b, req1_a, req1_b  input  N  operands.
REQ-007 SHALL have ports alu_select  output  4, alu_a  output  N, alu_b  output  N: drive to the shared ALU and flag generator.
REQ-008 SHALL have ports alu_result  input  N, alu_flags  input  2: combinational ALU return; bit0 zero, bit1 negative.
REQ-009 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1, rsp_result  output  N, rsp_flags  output  2: response channel.
REQ-010 SHALL have port flags_q  output  2: architectural flag register.

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-012 In IDLE, SHALL grant exactly one valid requester, assert its ready for that single cycle, latch id/op/operands, and go to EXEC.
REQ-013 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; last-grant pointer resets to 1, so req0 wins first.
REQ-014 SHALL keep both ready signals low in EXEC and RESP.
REQ-015 SHALL keep alu_select/alu_a/alu_b at the latched values in EXEC and RESP; in IDLE they SHALL be 0.
REQ-016 In EXEC, SHALL capture alu_result and alu_flags into the response registers and go to RESP; grant-to-rsp_valid latency is 2 cycles.
REQ-017 In EXEC, SHALL update flags_q from alu_flags:
  - bit0 only when op == 4
  - bit1 only when op <= 5, op == 9 or op == 10
  - otherwise bits hold.
REQ-018 In RESP, SHALL assert rsp_valid with stable rsp_id/rsp_result/rsp_flags until rsp_ready is high, then go to IDLE.
REQ-019 SHALL return to IDLE after the rsp_valid && rsp_ready cycle; the next grant occurs no earlier than the following cycle; throughput is at most 1 op per 3 cycles.
REQ-020 SHALL not drop or reorder requests; a non-granted valid requester SHALL wait with inputs held stable.
REQ-021 SHALL treat all N-bit values as unsigned bit vectors; no width extension or truncation.

Reset
REQ-022 On rst high at a clock edge, SHALL enter IDLE regardless of state; an in-flight op is discarded and no response is issued.
REQ-023 Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, flags_q 0, ready signals 0, alu_* outputs 0, last-grant pointer 1.
REQ-024 SHALL ignore requests during the reset cycle.

Configuration
REQ-025 Macro ALU_ARB_FIXED_PRIORITY_EN:
  - defined: req0 always wins simultaneous requests and the pointer is unused.
  - undefined: round-robin per REQ-013.

Verification
REQ-026 After reset, both valid, req0 op=4 a=3 b=3, req1 op=0 a=1 b=2:
  - req0_ready on cycle 1
  - rsp_id=0 on cycle 3
  - flags_q bit0=1 after EXEC
  - req1 granted next (round-robin).
REQ-027 req1 op=7, alu_result=4'b1000, flags_q previously 2'b11 -> flags_q stays 2'b11; rsp_flags equals alu_flags.
REQ-028 rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_result stable for all 5 cycles, no new ready asserted.
REQ-029 rst asserted during EXEC -> next cycle IDLE, rsp_valid 0, flags_q 0, no response delivered.
REQ-030 With ALU_ARB_FIXED_PRIORITY_EN defined, both requesters continuously valid for 4 ops -> all 4 grants go to req0.
